// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word behind a small output FIFO.
// Optional immediate range checking is enabled by defining INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder #(
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] count
);

    localparam int AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int PTR_W = AW + 1;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_ALUI   = 7'h13;
    localparam logic [6:0] OP_ALU    = 7'h33;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    // True when bits [31:lsb] of v are all copies of the same bit.
    function automatic logic upper_uniform(input logic [31:0] v, input int lsb);
        logic all1, all0;
        all1 = 1'b1;
        all0 = 1'b1;
        for (int b = 0; b < 32; b++) begin
            if (b >= lsb) begin
                all1 = all1 & v[b];
                all0 = all0 & ~v[b];
            end
        end
        return all1 | all0;
    endfunction

    // Returns {err, instr}.
    function automatic logic [32:0] encode(
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [31:0] instr;
        logic        err;
        logic        rng;
        instr = 32'h0000_0013;
        err   = 1'b0;
        rng   = 1'b0;
        case (op)
            OP_ALU: instr = {f7, rs2, rs1, f3, rd, op};
            OP_ALUI: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    instr = {f7, imm[4:0], rs1, f3, rd, op};
                    rng   = (imm[31:5] != 27'd0);
                end else begin
                    instr = {imm[11:0], rs1, f3, rd, op};
                    rng   = !upper_uniform(imm, 11);
                end
            end
            OP_LOAD, OP_JALR, OP_SYSTEM: begin
                instr = {imm[11:0], rs1, f3, rd, op};
                rng   = !upper_uniform(imm, 11);
            end
            OP_STORE: begin
                instr = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                rng   = !upper_uniform(imm, 11);
            end
            OP_BRANCH: begin
                instr = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                rng   = !upper_uniform(imm, 12) || imm[0];
            end
            OP_LUI, OP_AUIPC: begin
                instr = {imm[31:12], rd, op};
                rng   = (imm[11:0] != 12'd0);
            end
            OP_JAL: begin
                instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                rng   = !upper_uniform(imm, 20) || imm[0];
            end
            default: begin
                instr = 32'h0000_0013;
                err   = 1'b1;
            end
        endcase
`ifdef INSTR_ENC_RANGE_CHECK_EN
        err = err | rng;
`else
        rng = 1'b0;
`endif
        return {err | rng, instr};
    endfunction

    logic [32:0]      mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, push, pop;
    logic [32:0]      enc;
    logic [32:0]      head;

    assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Ready depends only on stored state (and reset), never on out_ready.
    assign in_ready  = rst_n && !full;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign enc       = encode(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign out_valid = !empty;
    assign out_instr = empty ? 32'd0 : head[31:0];
    assign out_err   = empty ? 1'b0 : head[32];
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= enc;
    end

endmodule
